// File: rtl/instr_fetch_seq_pkg.sv
// Shared encodings for the instruction fetch sequencer: state codes and opcode set.
// Latency: none (definitions only).
// Backpressure: not applicable.
package instr_fetch_seq_pkg;

  // Sequencer states; the numeric codes are visible to the datapath on current_state.
  typedef enum logic [3:0] {
    STATE_HLT     = 4'd0,
    STATE_FETCH0  = 4'd1,
    STATE_FETCH0W = 4'd2,
    STATE_FETCH1  = 4'd3,
    STATE_FETCH1W = 4'd4,
    STATE_EXEC    = 4'd5
  } state_t;

  // Opcode field occupies the top byte of the first instruction word.
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 24;

  // Opcode set understood by the datapath decoder.
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LIMM16 = 8'h01;
  localparam logic [7:0] OP_LIMM32 = 8'h02;
  localparam logic [7:0] OP_LBSET  = 8'h03;
  localparam logic [7:0] OP_ADD    = 8'h10;
  localparam logic [7:0] OP_SUB    = 8'h11;
  localparam logic [7:0] OP_AND    = 8'h12;
  localparam logic [7:0] OP_OR     = 8'h13;
  localparam logic [7:0] OP_XOR    = 8'h14;
  localparam logic [7:0] OP_JMP    = 8'h20;
  localparam logic [7:0] OP_JZ     = 8'h21;
  localparam logic [7:0] OP_END    = 8'h3F;

  // Extract the opcode byte from an instruction word.
  function automatic logic [7:0] op_of(input logic [31:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Classifies an opcode as legal and as one- or two-word.
// Latency: purely combinational.
// Backpressure: not applicable.
module instr_len_decode
  import instr_fetch_seq_pkg::*;
(
  input  logic [7:0] op,
  output logic       is_two_word,
  output logic       is_legal
);

  // Table lookup over the opcode set; anything unlisted is illegal and one-word.
  always_comb begin
    is_two_word = 1'b0;
    is_legal    = 1'b0;
    case (op)
      OP_LIMM32, OP_LBSET: begin
        is_two_word = 1'b1;
        is_legal    = 1'b1;
      end
      OP_NOP, OP_LIMM16, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_JMP, OP_JZ, OP_END: begin
        is_legal = 1'b1;
      end
      default: begin
        is_two_word = 1'b0;
        is_legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: owns pc, fetches one/two-word instructions, gates datapath writes to EXEC.
// Latency: 3 cycles per one-word instruction, 5 per two-word; memory read latency is 1 cycle.
// Backpressure: none; the sequencer free-runs until OP_END or an illegal opcode halts it.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              pc_we,
  input  logic [ADDR_W-1:0] pc_dw,
  output logic [3:0]        current_state,
  output logic [31:0]       instr0,
  output logic [31:0]       instr1,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr0_q, instr0_d;
  logic [31:0]       instr1_q, instr1_d;
  logic              err_q, err_d;

  logic              rd_two_word;
  logic              rd_legal;
  logic [ADDR_W-1:0] pc_inc;

  // Classify the word arriving from memory; only meaningful in FETCH0W.
  instr_len_decode u_len_decode (
    .op          (op_of(imem_rdata)),
    .is_two_word (rd_two_word),
    .is_legal    (rd_legal)
  );

  // pc wraps naturally at 2^ADDR_W.
  assign pc_inc = pc_q + ADDR_W'(1);

  // Next-state and next-value logic; every register holds unless a state says otherwise.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    err_d    = err_q;
    case (state_q)
      STATE_HLT: begin
        if (start) begin
          state_d = STATE_FETCH0;
          err_d   = 1'b0;
        end
      end
      STATE_FETCH0: begin
        state_d = STATE_FETCH0W;
      end
      STATE_FETCH0W: begin
        instr0_d = imem_rdata;
        pc_d     = pc_inc;
        if (!rd_legal) begin
          // Illegal word is still consumed so pc points past it after the halt.
          err_d   = 1'b1;
          state_d = STATE_HLT;
        end else if (rd_two_word) begin
          state_d = STATE_FETCH1;
        end else begin
          instr1_d = '0;
          state_d  = STATE_EXEC;
        end
      end
      STATE_FETCH1: begin
        state_d = STATE_FETCH1W;
      end
      STATE_FETCH1W: begin
        instr1_d = imem_rdata;
        pc_d     = pc_inc;
        state_d  = STATE_EXEC;
      end
      STATE_EXEC: begin
        // A jump load is honoured even when the instruction is OP_END.
        if (pc_we) begin
          pc_d = pc_dw;
        end
        if (op_of(instr0_q) == OP_END) begin
          state_d = STATE_HLT;
        end else begin
          state_d = STATE_FETCH0;
        end
      end
      default: begin
        state_d = STATE_HLT;
      end
    endcase
  end

  // State and instruction registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= STATE_HLT;
      pc_q     <= RESET_PC;
      instr0_q <= '0;
      instr1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      err_q    <= err_d;
    end
  end

  assign imem_addr     = pc_q;
  assign current_state = state_q;
  assign instr0        = instr0_q;
  assign instr1        = instr1_q;
  assign pc            = pc_q;
  assign halted        = (state_q == STATE_HLT);
  assign err           = err_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: per-cycle vector table plus bounded multi-cycle runs.
// Latency: checks exact per-state cycle counts.
// Backpressure: not applicable.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        pc_we;
  logic [15:0] pc_dw;
  logic [3:0]  current_state;
  logic [31:0] instr0;
  logic [31:0] instr1;
  logic [15:0] pc;
  logic        halted;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  instr_fetch_seq #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc_we         (pc_we),
    .pc_dw         (pc_dw),
    .current_state (current_state),
    .instr0        (instr0),
    .instr1        (instr1),
    .pc            (pc),
    .halted        (halted),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Synchronous memory model: one-cycle read latency, low 8 address bits decoded.
  always @(posedge clk) imem_rdata <= mem[imem_addr[7:0]];

  typedef struct {
    logic        rst;
    logic        st;
    logic        we;
    logic [15:0] dw;
    logic [3:0]  e_state;
    logic [15:0] e_pc;
    logic [31:0] e_i0;
    logic [31:0] e_i1;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 36;
  vec_t tbl [0:NVEC-1];

  function automatic vec_t mk(input logic rst, input logic st, input logic we,
                              input logic [15:0] dw, input logic [3:0] es,
                              input logic [15:0] ep, input logic [31:0] ei0,
                              input logic [31:0] ei1, input logic ee);
    vec_t v;
    v.rst = rst; v.st = st; v.we = we; v.dw = dw;
    v.e_state = es; v.e_pc = ep; v.e_i0 = ei0; v.e_i1 = ei1; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic chk_row(input int row, input vec_t v);
    chk("state",  row, 32'(current_state), 32'(v.e_state));
    chk("pc",     row, 32'(pc),            32'(v.e_pc));
    chk("addr",   row, 32'(imem_addr),     32'(v.e_pc));
    chk("instr0", row, instr0,             v.e_i0);
    chk("instr1", row, instr1,             v.e_i1);
    chk("err",    row, 32'(err),           32'(v.e_err));
    chk("halted", row, 32'(halted),        32'(v.e_state == 4'd0));
  endtask

  initial begin
    int n;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[8'h00] = 32'h0102_1234; // LIMM16
    mem[8'h01] = 32'h0204_0000; // LIMM32 first word
    mem[8'h02] = 32'hDEAD_BEEF; // LIMM32 immediate
    mem[8'h03] = 32'h1000_0000; // ADD
    mem[8'h10] = 32'h3F00_0000; // END
    mem[8'h11] = 32'hFF00_0000; // illegal
    mem[8'h20] = 32'hFF00_0000; // illegal
    mem[8'h21] = 32'h0300_0001; // LBSET first word
    mem[8'h22] = 32'h00AB_CDEF;
    mem[8'h40] = 32'h2000_0000; // JMP
    mem[8'hFF] = 32'h1400_0000; // XOR at 0xFFFF

    //            rst st we dw        state pc       instr0        instr1        err
    tbl[0]  = mk(0, 1, 0, 16'h0000, 4'd0, 16'h0000, 32'h0,        32'h0,        0);
    tbl[1]  = mk(0, 0, 0, 16'h0000, 4'd1, 16'h0000, 32'h0,        32'h0,        0);
    tbl[2]  = mk(0, 1, 1, 16'h0077, 4'd2, 16'h0000, 32'h0,        32'h0,        0);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 4'd5, 16'h0001, 32'h01021234, 32'h0,        0);
    tbl[4]  = mk(0, 0, 0, 16'h0000, 4'd1, 16'h0001, 32'h01021234, 32'h0,        0);
    tbl[5]  = mk(0, 0, 0, 16'h0000, 4'd2, 16'h0001, 32'h01021234, 32'h0,        0);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 4'd3, 16'h0002, 32'h02040000, 32'h0,        0);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 4'd4, 16'h0002, 32'h02040000, 32'h0,        0);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 4'd5, 16'h0003, 32'h02040000, 32'hDEADBEEF, 0);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 4'd1, 16'h0003, 32'h02040000, 32'hDEADBEEF, 0);
    tbl[10] = mk(0, 0, 0, 16'h0000, 4'd2, 16'h0003, 32'h02040000, 32'hDEADBEEF, 0);
    tbl[11] = mk(0, 0, 1, 16'h0040, 4'd5, 16'h0004, 32'h10000000, 32'h0,        0);
    tbl[12] = mk(0, 0, 0, 16'h0000, 4'd1, 16'h0040, 32'h10000000, 32'h0,        0);
    tbl[13] = mk(0, 0, 1, 16'h1234, 4'd2, 16'h0040, 32'h10000000, 32'h0,        0);
    tbl[14] = mk(0, 0, 1, 16'hFFFF, 4'd5, 16'h0041, 32'h20000000, 32'h0,        0);
    tbl[15] = mk(0, 0, 0, 16'h0000, 4'd1, 16'hFFFF, 32'h20000000, 32'h0,        0);
    tbl[16] = mk(0, 0, 0, 16'h0000, 4'd2, 16'hFFFF, 32'h20000000, 32'h0,        0);
    tbl[17] = mk(0, 0, 1, 16'h0010, 4'd5, 16'h0000, 32'h14000000, 32'h0,        0);
    tbl[18] = mk(0, 0, 0, 16'h0000, 4'd1, 16'h0010, 32'h14000000, 32'h0,        0);
    tbl[19] = mk(0, 0, 0, 16'h0000, 4'd2, 16'h0010, 32'h14000000, 32'h0,        0);
    tbl[20] = mk(0, 0, 1, 16'h0020, 4'd5, 16'h0011, 32'h3F000000, 32'h0,        0);
    tbl[21] = mk(0, 0, 1, 16'h0030, 4'd0, 16'h0020, 32'h3F000000, 32'h0,        0);
    tbl[22] = mk(0, 1, 0, 16'h0000, 4'd0, 16'h0020, 32'h3F000000, 32'h0,        0);
    tbl[23] = mk(0, 0, 0, 16'h0000, 4'd1, 16'h0020, 32'h3F000000, 32'h0,        0);
    tbl[24] = mk(0, 0, 0, 16'h0000, 4'd2, 16'h0020, 32'h3F000000, 32'h0,        0);
    tbl[25] = mk(0, 0, 0, 16'h0000, 4'd0, 16'h0021, 32'hFF000000, 32'h0,        1);
    tbl[26] = mk(0, 1, 0, 16'h0000, 4'd0, 16'h0021, 32'hFF000000, 32'h0,        1);
    tbl[27] = mk(0, 0, 0, 16'h0000, 4'd1, 16'h0021, 32'hFF000000, 32'h0,        0);
    tbl[28] = mk(0, 0, 0, 16'h0000, 4'd2, 16'h0021, 32'hFF000000, 32'h0,        0);
    tbl[29] = mk(0, 0, 0, 16'h0000, 4'd3, 16'h0022, 32'h03000001, 32'h0,        0);
    tbl[30] = mk(1, 0, 0, 16'h0000, 4'd4, 16'h0022, 32'h03000001, 32'h0,        0);
    tbl[31] = mk(0, 1, 0, 16'h0000, 4'd0, 16'h0000, 32'h0,        32'h0,        0);
    tbl[32] = mk(0, 0, 0, 16'h0000, 4'd1, 16'h0000, 32'h0,        32'h0,        0);
    tbl[33] = mk(0, 0, 0, 16'h0000, 4'd2, 16'h0000, 32'h0,        32'h0,        0);
    tbl[34] = mk(1, 0, 1, 16'h0055, 4'd5, 16'h0001, 32'h01021234, 32'h0,        0);
    tbl[35] = mk(0, 0, 0, 16'h0000, 4'd0, 16'h0000, 32'h0,        32'h0,        0);

    reset = 1'b1; start = 1'b0; pc_we = 1'b0; pc_dw = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Each row: observe outputs for this cycle, then drive the inputs sampled at the next edge.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      chk_row(i, tbl[i]);
      reset = tbl[i].rst;
      start = tbl[i].st;
      pc_we = tbl[i].we;
      pc_dw = tbl[i].dw;
    end

    // Free run from pc 0 with no jumps: 3+5+3 cycles, twelve NOPs, then END at 0x10.
    @(negedge clk);
    reset = 1'b0; start = 1'b1; pc_we = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!halted && n < 200) begin
      @(negedge clk);
      if (!halted) n++;
    end
    chk("run_halted", 100, 32'(halted), 32'd1);
    chk("run_cycles", 100, 32'(n),      32'd50);
    chk("run_pc",     100, 32'(pc),     32'h0011);
    chk("run_instr0", 100, instr0,      32'h3F000000);
    chk("run_err",    100, 32'(err),    32'd0);

    // Restart onto an illegal opcode: two fetch cycles, then halt with err.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!halted && n < 20) begin
      @(negedge clk);
      if (!halted) n++;
    end
    chk("ill_cycles", 101, 32'(n),      32'd2);
    chk("ill_err",    101, 32'(err),    32'd1);
    chk("ill_pc",     101, 32'(pc),     32'h0012);
    chk("ill_instr0", 101, instr0,      32'hFF000000);

    // Reset clears the sticky error.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_err",    102, 32'(err),           32'd0);
    chk("rst_pc",     102, 32'(pc),            32'h0000);
    chk("rst_state",  102, 32'(current_state), 32'd0);
    chk("rst_instr0", 102, instr0,             32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
